// File: rtl/sram_responder.sv
// Word-wide SRAM responder for the core memory handshake: one access at a time,
// fixed access latency, one-cycle mem_ready on completion and err on rejected requests.
module sram_responder #(
  parameter int unsigned BW      = 32,
  parameter int unsigned AW      = 12,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          read_en,
  input  logic          write_en,
  input  logic [BW-1:0] data_in,
  output logic [BW-1:0] data_out,
  output logic          mem_ready,
  output logic          busy,
  output logic          err
);

  localparam int unsigned IW = AW - 2;
  localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;

  logic [MW-1:0] idx_q;
  logic [BW-1:0] wdata_q;
  logic          op_write_q;

  logic [BW-1:0] mem [DEPTH];

  logic [IW-1:0] word_idx;
  logic          req_any;
  logic          req_ok;
  logic          accept;
  logic          do_access;
  logic          mem_ready_d;
  logic          err_d;
  logic          busy_d;

  // Request qualification: exactly one enable, word aligned, inside the array.
  assign word_idx = addr[AW-1:2];
  assign req_any  = read_en | write_en;
  assign req_ok   = (read_en ^ write_en) && (addr[1:0] == 2'b00) &&
                    ({1'b0, word_idx} < (IW+1)'(DEPTH));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    accept      = 1'b0;
    do_access   = 1'b0;
    mem_ready_d = 1'b0;
    err_d       = 1'b0;
    case (state)
      IDLE: begin
        if (req_ok) begin
          accept  = 1'b1;
          cnt_d   = CW'(LATENCY);
          state_d = WAIT;
        end else if (req_any) begin
          err_d = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          do_access   = 1'b1;
          mem_ready_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Captured request and registered outputs; an aborted access leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      data_out   <= '0;
      mem_ready  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        idx_q      <= addr[MW+1:2];
        wdata_q    <= data_in;
        op_write_q <= write_en;
      end
      if (do_access && !op_write_q) begin
        data_out <= mem[idx_q];
      end
      mem_ready <= mem_ready_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_access && op_write_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the core's `addr / read_en / write_en / data_in / data_out / mem_ready` memory handshake. It accepts one word read or write at a time, models fixed multi-cycle SRAM access latency, and signals completion with a one-cycle `mem_ready` pulse. It sits opposite the datapath's fetch/load/store port and is the storage that instruction fetch and load/store operations talk to.

## Interface
- `BW`, 32, data word width in bits.
- `AW`, 12, byte-address width.
- `DEPTH`, 1024, number of words in the array; must satisfy `DEPTH <= 2**(AW-2)`.
- `LATENCY`, 2, cycles from request acceptance to `mem_ready`; legal range 1..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `addr`  in  AW  byte address; word index is `addr[AW-1:2]`.
- `read_en`  in  1  read request, level-sampled while idle.
- `write_en`  in  1  write request, level-sampled while idle.
- `data_in`  in  BW  write data, sampled on the acceptance edge.
- `data_out`  out  BW  read data; holds its value until the next read completes.
- `mem_ready`  out  1  one-cycle completion pulse for reads and writes.
- `busy`  out  1  high whenever the state is not IDLE.
- `err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- FSM states: IDLE, WAIT, RESP. A 4-bit down-counter `cnt` tracks latency. The captured address, data, and operation are held in internal registers.
- **IDLE, valid request.** A request is valid when exactly one of `read_en`/`write_en` is high, `addr[1:0]==0`, and the word index is `< DEPTH`. On the edge:
  - latch `addr`, `data_in`, and the operation;
  - set `cnt = LATENCY`;
  - go to WAIT.
- **IDLE, rejected request.** Rejection causes are: both enables high, misaligned address, or word index `>= DEPTH`. On the edge: set `err=1` for the next cycle, perform no access, stay in IDLE.
- **IDLE, no request.** Both enables low: stay in IDLE, all pulses low.
- **WAIT.**
  - If `cnt==1`: perform the access on this edge and go to RESP. A write stores the latched data to the array. A read loads `array[index]` into `data_out`.
  - Otherwise: decrement `cnt`.
- **RESP.** `mem_ready=1` for exactly this one cycle, then return to IDLE unconditionally.
- **Requests while busy.** Enables asserted in WAIT or RESP are ignored, not queued. `err` stays 0. The initiator must hold the request until it is accepted.
- **Outputs on writes.** `data_out` does not change on write completion or on rejected requests.
- **Array contents.** The array is not reset; its contents are undefined until written.
- **Reset.** Reset mid-operation aborts the operation: state goes to IDLE and a pending write is discarded (the array is unchanged).

## Timing
- Reset values: state IDLE, `cnt=0`, `data_out=0`, `mem_ready=0`, `busy=0`, `err=0`.
- All outputs are registered; there are no combinational paths from input to output.
- Request accepted on edge k:
  - `busy` is high from after edge k until after edge k+LATENCY+1;
  - the access is committed on edge k+LATENCY;
  - `mem_ready` and the read data are visible in the cycle after edge k+LATENCY.
- Earliest next acceptance is edge k+LATENCY+2. Sustained throughput is one request per LATENCY+2 cycles.
- A rejected request on edge k gives `err` high in the cycle after edge k only. A request still held causes a new rejection pulse on every edge.
- Read-after-write to the same address returns the new data, since the write commits before the read can be accepted.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream → all outputs 0 and `busy=0` immediately (asynchronous), state IDLE.
- **Write then read:** write `0xDEADBEEF` to `addr 0x010`, then read `0x010` (LATENCY=2) → each `mem_ready` pulse comes 2 edges after acceptance; the read gives `data_out=0xDEADBEEF`; `data_out` is unchanged during the write.
- **Back-to-back:** hold `read_en` continuously on `addr 0x000, 0x004` → acceptances are 4 cycles apart; the second request is ignored while `busy=1`, with no `err`.
- **Rejection:** `read_en=write_en=1`; then `addr=0x013`; then word index 1024 with `DEPTH=1024` (AW=13 build) → `err` pulses each time, no `mem_ready`, memory unchanged.
- **Reset mid-write:** write `0x12345678` to `0x020`, drop `rst_n` during WAIT, then read `0x020` → the old value is returned and no `mem_ready` appears for the aborted write.
- **LATENCY=1 build:** read completes with `mem_ready` 1 edge after acceptance; throughput is one request per 3 cycles.
